// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and
// the default count width.
package timer_pkg;

    localparam int unsigned DEF_CNT_WIDTH = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : timer_pkg

// File: rtl/down_timer_if.sv
// Control/status bundle of the down-counting timer. The master side
// (software wrapper or bench) drives the requests; the timer (slave)
// returns the count and the status flags.
interface down_timer_if
    import timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);

    logic [CNT_WIDTH-1:0] load_val;
    logic                 periodic;
    logic                 start;
    logic                 stop;
    logic                 tick;
    logic                 irq_clr;
    logic [CNT_WIDTH-1:0] q;
    logic                 busy;
    logic                 done;
    logic                 irq;

    modport master (
        output load_val, periodic, start, stop, tick, irq_clr,
        input  q, busy, done, irq
    );

    modport slave (
        input  load_val, periodic, start, stop, tick, irq_clr,
        output q, busy, done, irq
    );

endinterface : down_timer_if

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Expiry produces a registered one-cycle done pulse and sets a sticky irq.
// Same-cycle priority: stop > start > expiry > plain decrement.
module down_timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    down_timer_if.slave   bus
);

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] q_r, q_n;
    logic [CNT_WIDTH-1:0] reload_reg, reload_n;
    logic                 periodic_reg, periodic_n;
    logic                 done_r, done_n;
    logic                 irq_r, irq_n;
    logic                 start_ok;

    // A start only counts when it carries a non-zero load value.
    assign start_ok = bus.start && (bus.load_val != '0);

    // Next-state, count datapath and flag update, resolved by priority.
    always_comb begin
        state_n    = state;
        q_n        = q_r;
        reload_n   = reload_reg;
        periodic_n = periodic_reg;
        done_n     = 1'b0;
        irq_n      = irq_r && !bus.irq_clr;

        if (bus.stop) begin
            // Abort; q freezes where it is and the start (if any) is dropped.
            state_n = ST_IDLE;
        end else if (start_ok) begin
            q_n        = bus.load_val;
            reload_n   = bus.load_val;
            periodic_n = bus.periodic;
            state_n    = ST_RUN;
        end else if (state == ST_RUN && bus.tick) begin
            if (q_r == CNT_WIDTH'(1)) begin
                done_n = 1'b1;
                irq_n  = 1'b1;
                if (periodic_reg) begin
                    q_n = reload_reg;
                end else begin
                    q_n     = '0;
                    state_n = ST_IDLE;
                end
            end else if (q_r > CNT_WIDTH'(1)) begin
                q_n = q_r - CNT_WIDTH'(1);
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            q_r          <= '0;
            reload_reg   <= '0;
            periodic_reg <= 1'b0;
            done_r       <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            state        <= state_n;
            q_r          <= q_n;
            reload_reg   <= reload_n;
            periodic_reg <= periodic_n;
            done_r       <= done_n;
            irq_r        <= irq_n;
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = (state == ST_RUN);
    assign bus.done = done_r;
    assign bus.irq  = irq_r;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: each stimulus step pushes the expected
// post-edge outputs; a monitor pops and compares one entry per clock.
module tb_down_timer;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         irq;
        string        tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    exp_t sb[$];

    down_timer_if #(.CNT_WIDTH(W)) bus ();

    down_timer #(.CNT_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, ".q"},    bus.q,         e.q);
                chk({e.tag, ".busy"}, W'(bus.busy),  W'(e.busy));
                chk({e.tag, ".done"}, W'(bus.done),  W'(e.done));
                chk({e.tag, ".irq"},  W'(bus.irq),   W'(e.irq));
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic step(input string tag, input logic st, input logic sp, input logic tk,
                        input logic per, input logic [W-1:0] lv, input logic clr,
                        input logic [W-1:0] eq, input logic eb, input logic ed, input logic ei);
        exp_t e;
        @(negedge clk);
        bus.start    = st;
        bus.stop     = sp;
        bus.tick     = tk;
        bus.periodic = per;
        bus.load_val = lv;
        bus.irq_clr  = clr;
        e.q = eq; e.busy = eb; e.done = ed; e.irq = ei; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic tk1(input string tag, input logic [W-1:0] eq, input logic eb,
                       input logic ed, input logic ei);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, eq, eb, ed, ei);
    endtask

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b1;
        bus.periodic = 1'b0; bus.load_val = '0; bus.irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.q", bus.q, '0);
        chk("rst.busy", W'(bus.busy), '0);
        chk("rst.done", W'(bus.done), '0);
        chk("rst.irq", W'(bus.irq), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, load 5.
        step("os.start", 1, 0, 1, 0, 5, 0, 5, 1, 0, 0);
        tk1("os.4", 4, 1, 0, 0);
        tk1("os.3", 3, 1, 0, 0);
        tk1("os.2", 2, 1, 0, 0);
        tk1("os.1", 1, 1, 0, 0);
        tk1("os.exp", 0, 0, 1, 1);
        tk1("os.after", 0, 0, 0, 1);
        step("os.clr", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);

        // Periodic, load 3: done at 3, 6, 9.
        step("per.start", 1, 0, 1, 1, 3, 0, 3, 1, 0, 0);
        tk1("per.c1", 2, 1, 0, 0);
        tk1("per.c2", 1, 1, 0, 0);
        tk1("per.c3", 3, 1, 1, 1);
        tk1("per.c4", 2, 1, 0, 1);
        tk1("per.c5", 1, 1, 0, 1);
        tk1("per.c6", 3, 1, 1, 1);
        tk1("per.c7", 2, 1, 0, 1);
        tk1("per.c8", 1, 1, 0, 1);
        tk1("per.c9", 3, 1, 1, 1);
        tk1("per.c10", 2, 1, 0, 1);
        step("per.stop", 0, 1, 1, 0, 0, 0, 2, 0, 0, 1);
        step("per.clr", 0, 0, 1, 0, 0, 1, 2, 0, 0, 0);

        // Load 4 with tick toggling: expiry after 8 cycles.
        step("tog.start", 1, 0, 1, 0, 4, 0, 4, 1, 0, 0);
        step("tog.c1", 0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
        step("tog.c2", 0, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        step("tog.c3", 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        step("tog.c4", 0, 0, 1, 0, 0, 0, 2, 1, 0, 0);
        step("tog.c5", 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        step("tog.c6", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        step("tog.c7", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("tog.c8", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        step("tog.c9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("tog.clr", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Load 10, stop at q==6, then a zero-load start is ignored.
        step("stp.start", 1, 0, 1, 0, 10, 0, 10, 1, 0, 0);
        tk1("stp.9", 9, 1, 0, 0);
        tk1("stp.8", 8, 1, 0, 0);
        tk1("stp.7", 7, 1, 0, 0);
        tk1("stp.6", 6, 1, 0, 0);
        step("stp.stop", 0, 1, 1, 0, 0, 0, 6, 0, 0, 0);
        step("stp.zero", 1, 0, 1, 0, 0, 0, 6, 0, 0, 0);
        tk1("stp.idle", 6, 0, 0, 0);
        step("stp.idlestop", 0, 1, 1, 0, 0, 0, 6, 0, 0, 0);

        // Expiry coincident with irq_clr: set wins.
        step("cf.s1", 1, 0, 1, 0, 2, 0, 2, 1, 0, 0);
        tk1("cf.s1a", 1, 1, 0, 0);
        tk1("cf.s1e", 0, 0, 1, 1);
        step("cf.s2", 1, 0, 1, 0, 2, 0, 2, 1, 0, 1);
        tk1("cf.s2a", 1, 1, 0, 1);
        step("cf.expclr", 0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        step("cf.clr", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        // Start coincident with expiry: restart, no done, no irq.
        step("cf.s3", 1, 0, 1, 0, 2, 0, 2, 1, 0, 0);
        tk1("cf.s3a", 1, 1, 0, 0);
        step("cf.restart", 1, 0, 1, 0, 7, 0, 7, 1, 0, 0);
        tk1("cf.6", 6, 1, 0, 0);
        // Stop in the expiry cycle: abort, no done, no irq.
        step("cf.s4", 1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
        step("cf.stopexp", 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        // Stop + start together: start dropped.
        step("cf.stopstart", 1, 1, 1, 0, 9, 0, 1, 0, 0, 0);
        // All-ones load value is legal.
        step("max.start", 1, 0, 1, 0, ones, 0, ones, 1, 0, 0);
        tk1("max.dec", ones - 1, 1, 0, 0);
        step("max.stop", 0, 1, 1, 0, 0, 0, ones - 1, 0, 0, 0);

        // Asynchronous reset mid-count at q==3.
        step("ar.start", 1, 0, 1, 0, 5, 0, 5, 1, 0, 0);
        tk1("ar.4", 4, 1, 0, 0);
        tk1("ar.3", 3, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.q", bus.q, '0);
        chk("ar.busy", W'(bus.busy), '0);
        chk("ar.done", W'(bus.done), '0);
        chk("ar.irq", W'(bus.irq), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tk1("ar.post1", 0, 0, 0, 0);
        tk1("ar.post2", 0, 0, 0, 0);
        tk1("ar.post3", 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb.drained", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_down_timer

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer for the GCD accelerator AXI4-Lite wrapper.
- Software programs a cycle count and starts the timer. The block decrements on each enabled tick and flags expiry with a one-cycle pulse plus a sticky interrupt.
- Supports one-shot and periodic (auto-reload) modes.
- Sits beside the cycle counter: that block measures elapsed time; this block generates timeouts and periodic events.

Parameters:
- CNT_WIDTH, 64, width of load value and count register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- load_val  input  CNT_WIDTH  start value; sampled only on an accepted start.
- periodic  input  1  mode select; sampled only on an accepted start (1 = auto-reload, 0 = one-shot).
- start  input  1  single-cycle request to (re)start counting.
- stop  input  1  single-cycle request to abort counting.
- tick  input  1  count enable / prescaler strobe; tie high for per-cycle counting.
- irq_clr  input  1  clears the sticky irq.
- q  output  CNT_WIDTH  current count value.
- busy  output  1  high while in RUN.
- done  output  1  registered one-cycle expiry pulse.
- irq  output  1  sticky expiry flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, q=0, reload_reg=0, periodic_reg=0, busy=0, done=0, irq=0.
- Reset mid-count aborts immediately; no done pulse is produced.
- States:
  - IDLE: q holds its last value.
  - RUN: counting.
- Accepted start (any state, stop low, load_val != 0):
  - q<=load_val, reload_reg<=load_val, periodic_reg<=periodic, state<=RUN.
- start with load_val==0 is ignored: state, q and flags are unchanged.
- In RUN with tick=1 and q>1: q<=q-1.
- In RUN with tick=0: q holds.
- Expiry event = RUN && tick && q==1. On that edge:
  - done<=1 for exactly one cycle.
  - irq<=1.
  - One-shot (periodic_reg=0): q<=0, state<=IDLE.
  - Periodic (periodic_reg=1): q<=reload_reg, stay in RUN.
- Period: with tick tied high and load_val=N, done is high exactly N cycles after the start edge. In periodic mode it repeats every N cycles.
- stop in RUN: state<=IDLE, q frozen at current value, no done, no irq change.
- stop in IDLE has no effect.
- busy = (state==RUN), registered via state.
- done is 0 in every cycle without an expiry event.
- irq_clr clears irq to 0 on the next edge.
- Same-cycle priority (highest first): stop > start > expiry > plain decrement.
  - stop+start: abort; the start is dropped.
  - start during RUN (incl. the expiry cycle): restart with the new load_val; no done, no irq set for that cycle.
  - stop in the expiry cycle: abort; no done, no irq.
  - expiry + irq_clr: set wins, irq stays 1.
- Arithmetic is unsigned CNT_WIDTH.
- q never underflows: 0 is reached only via one-shot expiry, and decrement is never applied at q<=1.
- load_val = all-ones is legal; it gives the maximum period of 2^CNT_WIDTH-1 ticks.

Decomposition:
- Shared package timer_pkg: state encodings ST_IDLE=1'b0, ST_RUN=1'b1; default CNT_WIDTH=64.
- No sub-module: the decrement/reload/compare datapath and 2-state FSM fit in one module.
- The existing counter block is not reused; its up-count semantics differ.

Test Plan:
- Reset then start with load_val=5, periodic=0, tick=1:
  - q runs 5,4,3,2,1,0.
  - done high in the single cycle q first reads 0 (5 cycles after start).
  - busy falls with it; irq=1 thereafter.
- periodic=1, load_val=3, tick=1, run for 10 cycles:
  - done pulses at cycles 3, 6, 9 after start.
  - q sequence 3,2,1,3,2,1,3…; busy stays 1.
- load_val=4, tick toggling 1,0,1,0…:
  - expiry takes 8 cycles.
  - q holds during tick=0 cycles.
  - exactly one done pulse.
- load_val=10, stop asserted when q==6:
  - state IDLE, q frozen at 6, no done, irq unchanged.
  - A following start with load_val=0 is ignored (q stays 6, busy 0).
- Same-cycle conflicts:
  - irq=1, then expiry coincident with irq_clr: irq remains 1.
  - Later irq_clr alone: irq=0.
  - start coincident with expiry (q==1, load_val=7): q=7, no done.
- rst_n asserted low mid-count (q==3), asynchronously between edges:
  - q, busy, done, irq all 0 immediately.
  - No done pulse after rst_n releases.
